// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, types and ALU op encodings for the execution units
package cpu_defs;

    localparam int WORD_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [TAG_W-1:0]  regtag_t;
    typedef logic [OP_W-1:0]   sinst_t;
    typedef logic [4:0]        regaddr_t;
    typedef logic [31:0]       pc_t;

    // All-ones tag marks an operand (or bus) as carrying no pending producer.
    localparam regtag_t UNLOCKED = '1;

    localparam sinst_t ALU_ADD   = 6'd0;
    localparam sinst_t ALU_SUB   = 6'd1;
    localparam sinst_t ALU_AND   = 6'd2;
    localparam sinst_t ALU_OR    = 6'd3;
    localparam sinst_t ALU_XOR   = 6'd4;
    localparam sinst_t ALU_SLL   = 6'd5;
    localparam sinst_t ALU_SRL   = 6'd6;
    localparam sinst_t ALU_SRA   = 6'd7;
    localparam sinst_t ALU_SLT   = 6'd8;
    localparam sinst_t ALU_SLTU  = 6'd9;
    localparam sinst_t ALU_LUI   = 6'd10;
    localparam sinst_t ALU_AUIPC = 6'd11;
    localparam sinst_t ALU_JAL   = 6'd12;
    localparam sinst_t ALU_JALR  = 6'd13;

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - RS-slot entry, CDB request/grant and snoop bus of one ALU execution unit
interface alu_exec_if;
    import cpu_defs::*;

    logic     in_busy;
    sinst_t   in_op;
    pc_t      in_pc;
    regtag_t  in_tagx;
    regtag_t  in_tagy;
    regtag_t  in_tagw;
    word_t    in_datax;
    word_t    in_datay;
    regaddr_t in_target;
    logic     accept;
    logic     cdb_req;
    logic     cdb_grant;
    logic     out_busy;
    regtag_t  out_tag;
    word_t    out_data;
    regaddr_t out_target;

    modport master (
        output in_busy, in_op, in_pc, in_tagx, in_tagy, in_tagw,
               in_datax, in_datay, in_target, cdb_grant,
        input  accept, cdb_req, out_busy, out_tag, out_data, out_target
    );

    modport slave (
        input  in_busy, in_op, in_pc, in_tagx, in_tagy, in_tagw,
               in_datax, in_datay, in_target, cdb_grant,
        output accept, cdb_req, out_busy, out_tag, out_data, out_target
    );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer ALU: op/x/y/pc to result
module alu_core
    import cpu_defs::*;
(
    input  sinst_t op,
    input  word_t  x,
    input  word_t  y,
    input  pc_t    pc,
    output word_t  result
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(x) < $signed(y);
    assign lt_unsigned = x < y;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = x + y;
            ALU_SUB:   result = x - y;
            ALU_AND:   result = x & y;
            ALU_OR:    result = x | y;
            ALU_XOR:   result = x ^ y;
            ALU_SLL:   result = x << y[4:0];
            ALU_SRL:   result = x >> y[4:0];
            ALU_SRA:   result = $signed(x) >>> y[4:0];
            ALU_SLT:   result = {{(WORD_W-1){1'b0}}, lt_signed};
            ALU_SLTU:  result = {{(WORD_W-1){1'b0}}, lt_unsigned};
            ALU_LUI:   result = y;
            ALU_AUIPC: result = pc + y;
            ALU_JAL:   result = pc + 32'd4;
            ALU_JALR:  result = pc + 32'd4;
            // Undefined ops still broadcast, carrying zero.
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - single-issue ALU execution unit holding its result until the CDB grants a broadcast
module alu_exec
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       flush,
    alu_exec_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DONE  = 2'd1;
    localparam logic [1:0] S_BCAST = 2'd2;

    logic [1:0] state;
    word_t      res_data;
    regtag_t    res_tag;
    regaddr_t   res_target;
    word_t      alu_result;
    logic       accept;

    // A new entry may land in the BCAST cycle, giving one result every two cycles.
    assign accept = rdy & bus.in_busy
                  & (bus.in_tagx == UNLOCKED) & (bus.in_tagy == UNLOCKED)
                  & ((state == S_IDLE) | (state == S_BCAST))
                  & ~flush;

    alu_core u_core (
        .op     (bus.in_op),
        .x      (bus.in_datax),
        .y      (bus.in_datay),
        .pc     (bus.in_pc),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            res_data   <= '0;
            res_tag    <= UNLOCKED;
            res_target <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            state      <= S_DONE;
            res_data   <= alu_result;
            res_tag    <= bus.in_tagw;
            res_target <= bus.in_target;
        end else if (rdy) begin
            case (state)
                S_DONE:  if (bus.cdb_grant) state <= S_BCAST;
                S_BCAST: state <= S_IDLE;
                S_IDLE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.accept     = accept;
    assign bus.cdb_req    = (state == S_DONE);
    assign bus.out_busy   = (state != S_BCAST);
    assign bus.out_tag    = (state == S_BCAST) ? res_tag : UNLOCKED;
    assign bus.out_data   = res_data;
    assign bus.out_target = res_target;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Single-issue integer execution unit directly downstream of the ALU reservation station.
- Accepts one operand-ready entry from its RS slot, computes the result, and holds it until the common data bus (CDB) arbiter grants a one-cycle broadcast of {tag, data}.
- Drives the busy/tag/data triple that the RS and the other stations snoop for operand wake-up.
- One instance is built per RS slot (two in the current core).

Parameters:
- WORD_W, 32, datapath width (word_t).
- TAG_W, 4, reorder tag width (regtag_t); the all-ones tag is UNLOCKED.
- OP_W, 6, decoded op width (sinst_t).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- flush  in  1  branch mispredict; kills any in-flight entry.
- in_busy  in  1  RS slot holds a valid entry.
- in_op  in  OP_W  decoded op.
- in_pc  in  32  instruction pc.
- in_tagx, in_tagy  in  TAG_W  operand tags; UNLOCKED means the data is valid.
- in_tagw  in  TAG_W  destination tag.
- in_datax, in_datay  in  WORD_W  operand values.
- in_target  in  5  destination register address.
- accept  out  1  combinational; the entry is taken this cycle.
- cdb_req  out  1  result waiting for the bus.
- cdb_grant  in  1  arbiter grant, valid only while cdb_req is high.
- out_busy  out  1  low exactly in the broadcast cycle, high otherwise while occupied.
- out_tag  out  TAG_W  broadcast tag; UNLOCKED when not broadcasting.
- out_data  out  WORD_W  broadcast result.
- out_target  out  5  destination register for the broadcast.

Behaviour:
- States:
  - IDLE: no entry held.
  - DONE: result registered, cdb_req=1.
  - BCAST: one-cycle broadcast, out_busy=0, out_tag=tagw.
- Reset:
  - State is IDLE.
  - cdb_req=0, out_busy=1, out_tag=UNLOCKED, out_data=0, out_target=0.
  - Reset is asserted asynchronously and released synchronously through a 2-flop synchroniser in the parent.
- Accept:
  - accept = rdy & in_busy & (in_tagx==UNLOCKED) & (in_tagy==UNLOCKED) & (state==IDLE | state==BCAST) & ~flush.
- Timing:
  - Accept in cycle N registers the result, with state DONE, at edge N+1.
  - Earliest BCAST is cycle N+2 if cdb_grant is sampled high in N+1.
- DONE handling:
  - DONE with grant → BCAST.
  - DONE without grant → hold DONE; data and tag stay stable.
- BCAST handling:
  - BCAST always lasts exactly one cycle.
  - Next state is DONE if accept in that cycle, otherwise IDLE. This gives back-to-back throughput of one result per 2 cycles.
- Ops (combinational, registered at accept), with x=datax, y=datay:
  - ADD x+y; SUB x−y.
  - AND, OR, XOR.
  - SLL, SRL, SRA shift by y[4:0].
  - SLT signed compare; SLTU unsigned compare (result 0 or 1).
  - LUI y; AUIPC pc+y.
  - JAL and JALR pc+4.
  - Undefined op → result 0, still broadcast.
- Arithmetic: all results truncate to WORD_W; no overflow trap.
- Flush:
  - Highest priority.
  - Next state IDLE, cdb_req=0, out_tag=UNLOCKED.
  - A grant arriving in the same cycle is ignored; the arbiter tolerates the dropped grant.
- rdy low:
  - Every register holds, accept=0, cdb_req keeps its value.
  - A grant seen while rdy=0 is ignored.
- Simultaneous grant and new entry in DONE: the new entry is not accepted until BCAST.
- Grant while not in DONE: ignored.

Decomposition:
- Shared package (cpu_defs):
  - word_t, regtag_t, sinst_t, regaddr_t.
  - UNLOCKED.
  - op encodings ALU_ADD…ALU_JALR.
- Sub-module: alu_core, purely combinational op/x/y/pc → result.
- The FSM, handshake and registers stay in alu_exec.

Test Plan:
- ADD: in_busy=1, tagx=tagy=UNLOCKED, op=ADD, x=0x7FFFFFFF, y=1, tagw=3, grant held high → accept in cycle 0, cdb_req in cycle 1, BCAST in cycle 2 with out_tag=3, out_data=0x80000000, out_busy=0.
- Operand wait: tagx=5 for 3 cycles, then UNLOCKED → accept stays 0 until the tag unlocks; op=SRA, x=0x80000000, y=4 → data 0xF8000000.
- Grant stall: result ready with grant low for 4 cycles → cdb_req=1 and data stable throughout; grant in cycle 5 → broadcast in cycle 6.
- Flush in DONE with grant high → next cycle IDLE, out_tag=UNLOCKED, no broadcast.
- Back-to-back: second entry presented during BCAST → accepted in that cycle; second BCAST exactly 2 cycles after the first.
- Async reset: rst_n pulsed low mid-DONE between clock edges → outputs reach reset values immediately; rdy=0 for 2 cycles during DONE → no state change.
